// File: rtl/countdown_sequencer.sv
// countdown_sequencer: mm:ss BCD countdown with button digit edit; define PRESET_RESTORE_EN to reload the pre-run time when a finished count is stopped
module countdown_sequencer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [1:0] i_choose,
  input  logic       i_B_U,
  input  logic       i_B_D,
  output logic [3:0] o_segs0,
  output logic [3:0] o_segs1,
  output logic [3:0] o_mins0,
  output logic [3:0] o_mins1,
  output logic       o_tick,
  output logic       o_zero
);
  localparam logic [26:0] LAST = 27'(TICK_DIV - 1);
  logic [3:0]  r_d [4];
  logic [3:0]  w_next [4];
  logic [26:0] r_presc;
  logic        r_prev_u, r_prev_d, r_tick;
  logic        w_up, w_dn, w_zero, w_last, w_dec, w_edit;
  function automatic logic [3:0] f_step(input logic [3:0] d, input logic [3:0] m, input logic up);
    return up ? (d == m ? 4'd0 : d + 4'd1) : (d == 4'd0 ? m : d - 4'd1);
  endfunction
  assign w_up   = i_B_U & ~r_prev_u;
  assign w_dn   = i_B_D & ~r_prev_d;
  assign w_zero = ~|{r_d[3], r_d[2], r_d[1], r_d[0]};
  assign w_last = r_presc == LAST;
  assign w_dec  = i_run & ~w_zero & w_last;
  assign w_edit = ~i_run & (w_up ^ w_dn);
`ifdef PRESET_RESTORE_EN
  logic [15:0] r_preset;
  logic        r_run_d;
  logic        w_reload;
  assign w_reload = ~i_run & r_run_d & w_zero;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_preset <= '0;
      r_run_d  <= 1'b0;
    end else begin
      r_run_d <= i_run;
      if (i_run & ~r_run_d) r_preset <= {r_d[3], r_d[2], r_d[1], r_d[0]};
    end
`endif
  // each digit borrows only when every lower digit is already 0
  always_comb begin
    w_next = r_d;
    if (w_edit) w_next[i_choose] = f_step(r_d[i_choose], i_choose == 2'd1 ? 4'd5 : 4'd9, w_up);
    else if (w_dec) begin
      w_next[0] = r_d[0] == 4'd0 ? 4'd9 : r_d[0] - 4'd1;
      w_next[1] = r_d[0] != 4'd0 ? r_d[1] : r_d[1] == 4'd0 ? 4'd5 : r_d[1] - 4'd1;
      w_next[2] = |{r_d[1], r_d[0]} ? r_d[2] : r_d[2] == 4'd0 ? 4'd9 : r_d[2] - 4'd1;
      w_next[3] = |{r_d[2], r_d[1], r_d[0]} ? r_d[3] : r_d[3] - 4'd1;
    end
`ifdef PRESET_RESTORE_EN
    if (w_reload) {w_next[3], w_next[2], w_next[1], w_next[0]} = r_preset;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_d      <= '{default: '0};
      r_presc  <= '0;
      r_prev_u <= 1'b0;
      r_prev_d <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_d      <= w_next;
      r_presc  <= !i_run ? '0 : w_zero ? r_presc : w_last ? '0 : r_presc + 27'd1;
      r_prev_u <= i_B_U;
      r_prev_d <= i_B_D;
      r_tick   <= w_dec;
    end
  assign o_segs0 = r_d[0];
  assign o_segs1 = r_d[1];
  assign o_mins0 = r_d[2];
  assign o_mins1 = r_d[3];
  assign o_tick  = r_tick;
  assign o_zero  = w_zero;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed and randomized checks of countdown_sequencer against a seconds-based reference model
module tb_countdown_sequencer;
  localparam int TDIV = 4;
`ifdef PRESET_RESTORE_EN
  localparam bit PRESET = 1'b1;
`else
  localparam bit PRESET = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, i_run = 1'b0, i_B_U = 1'b0, i_B_D = 1'b0;
  logic [1:0] i_choose = 2'd0;
  logic [3:0] o_segs0, o_segs1, o_mins0, o_mins1;
  logic o_tick, o_zero;
  logic [15:0] dut_time;
  int vec = 0, miss = 0;
  int m_d [4];
  int m_preset [4];
  int m_cnt;
  bit m_pu, m_pd, m_prun, m_tick;

  countdown_sequencer #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_choose(i_choose),
    .i_B_U(i_B_U), .i_B_D(i_B_D),
    .o_segs0(o_segs0), .o_segs1(o_segs1), .o_mins0(o_mins0), .o_mins1(o_mins1),
    .o_tick(o_tick), .o_zero(o_zero)
  );

  always #5 clk = ~clk;
  assign dut_time = {o_mins1, o_mins0, o_segs1, o_segs0};

  function automatic logic [15:0] m_time();
    return {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
  endfunction

  function automatic bit m_zero();
    return (m_d[0] + m_d[1] + m_d[2] + m_d[3]) == 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_d[i] = 0; m_preset[i] = 0; end
    m_cnt = 0; m_pu = 0; m_pd = 0; m_prun = 0; m_tick = 0;
  endtask

  // model works in whole seconds for counting and per-digit modulo for editing
  task automatic model_edge(input bit r, input logic [1:0] c, input bit u, input bit d);
    bit zero, up, dn;
    int secs, lim;
    zero = m_zero();
    up = u && !m_pu;
    dn = d && !m_pd;
    m_tick = 0;
    if (PRESET && r && !m_prun) m_preset = m_d;
    if (!r) begin
      m_cnt = 0;
      if (PRESET && m_prun && zero) m_d = m_preset;
      else if (up != dn) begin
        lim = (c == 2'd1) ? 6 : 10;
        m_d[c] = up ? (m_d[c] + 1) % lim : (m_d[c] + lim - 1) % lim;
      end
    end else if (!zero) begin
      m_cnt++;
      if (m_cnt == TDIV) begin
        m_cnt = 0;
        secs = m_d[3] * 600 + m_d[2] * 60 + m_d[1] * 10 + m_d[0] - 1;
        m_d[3] = secs / 600;
        m_d[2] = (secs / 60) % 10;
        m_d[1] = (secs % 60) / 10;
        m_d[0] = secs % 10;
        m_tick = 1;
      end
    end
    m_pu = u; m_pd = d; m_prun = r;
  endtask

  task automatic tick(input bit r, input logic [1:0] c, input bit u, input bit d);
    i_run = r; i_choose = c; i_B_U = u; i_B_D = d;
    @(posedge clk);
    model_edge(r, c, u, d);
    #1;
  endtask

  task automatic do_reset();
    i_run = 0; i_B_U = 0; i_B_D = 0; reset = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic press(input logic [1:0] c, input bit up);
    tick(0, c, up, !up);
    tick(0, c, 0, 0);
  endtask

  task automatic test_reset();
    reset = 0;
    #1;
    vec++; if (dut_time !== 16'h0000) begin miss++; $display("FAIL reset_digits: got %h want 0000", dut_time); end
    vec++; if (o_zero !== 1'b1) begin miss++; $display("FAIL reset_zero: got %b want 1", o_zero); end
    vec++; if (o_tick !== 1'b0) begin miss++; $display("FAIL reset_tick: got %b want 0", o_tick); end
    do_reset();
    vec++; if ({dut_time, o_zero, o_tick} !== {16'h0000, 1'b1, 1'b0}) begin
      miss++; $display("FAIL reset_release: got %h z=%b t=%b want 0000 z=1 t=0", dut_time, o_zero, o_tick);
    end
  endtask

  task automatic test_edit_wrap();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      press(2'd1, 1);
      vec++; if (dut_time !== {8'h00, 4'(k % 6), 4'h0}) begin
        miss++; $display("FAIL edit_wrap press %0d: got %h want %h", k, dut_time, {8'h00, 4'(k % 6), 4'h0});
      end
    end
  endtask

  task automatic test_down_hold();
    do_reset();
    press(2'd0, 1);
    press(2'd3, 0);
    vec++; if (dut_time !== 16'h9001) begin miss++; $display("FAIL down_wrap: got %h want 9001", dut_time); end
    for (int k = 0; k < 10; k++) begin
      tick(0, 2'd3, 1, 0);
      vec++; if (dut_time !== 16'h0001) begin miss++; $display("FAIL hold_up cycle %0d: got %h want 0001", k, dut_time); end
    end
    tick(0, 2'd3, 0, 0);
    tick(0, 2'd3, 1, 1);
    vec++; if (dut_time !== 16'h0001) begin miss++; $display("FAIL up_and_down: got %h want 0001", dut_time); end
    tick(0, 2'd3, 0, 0);
  endtask

  task automatic test_countdown();
    logic [15:0] et;
    do_reset();
    press(2'd3, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 2'd0, 0, 0);
      et = k < 4 ? 16'h1000 : k < 8 ? 16'h0959 : 16'h0958;
      vec++; if (dut_time !== et) begin miss++; $display("FAIL countdown edge %0d: got %h want %h", k, dut_time, et); end
      vec++; if (o_tick !== (k == 4 || k == 8)) begin
        miss++; $display("FAIL countdown_tick edge %0d: got %b want %b", k, o_tick, (k == 4 || k == 8));
      end
    end
    tick(0, 2'd0, 0, 0);
  endtask

  task automatic test_zero_hold();
    do_reset();
    press(2'd0, 1);
    repeat (TDIV) tick(1, 2'd0, 0, 0);
    vec++; if ({dut_time, o_zero, o_tick} !== {16'h0000, 1'b1, 1'b1}) begin
      miss++; $display("FAIL reach_zero: got %h z=%b t=%b want 0000 z=1 t=1", dut_time, o_zero, o_tick);
    end
    for (int k = 0; k < 20; k++) begin
      tick(1, 2'd0, 0, 0);
      vec++; if ({dut_time, o_zero, o_tick} !== {16'h0000, 1'b1, 1'b0}) begin
        miss++; $display("FAIL zero_hold cycle %0d: got %h z=%b t=%b want 0000 z=1 t=0", k, dut_time, o_zero, o_tick);
      end
    end
  endtask

  task automatic test_pause();
    logic [15:0] et;
    do_reset();
    press(2'd3, 1);
    tick(1, 2'd0, 0, 0);
    tick(1, 2'd0, 0, 0);
    tick(0, 2'd0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1, 2'd0, k >= 2, 0);
      et = k < 4 ? 16'h1000 : 16'h0959;
      vec++; if ({dut_time, o_tick} !== {et, k == 4}) begin
        miss++; $display("FAIL pause_resume edge %0d: got %h t=%b want %h t=%b", k, dut_time, o_tick, et, k == 4);
      end
    end
    tick(0, 2'd0, 1, 0);
    vec++; if (dut_time !== 16'h0959) begin miss++; $display("FAIL held_through_run: got %h want 0959", dut_time); end
    tick(0, 2'd0, 0, 0);
  endtask

  task automatic test_preset();
    logic [15:0] et;
    do_reset();
    repeat (3) press(2'd0, 1);
    repeat (3 * TDIV) tick(1, 2'd0, 0, 0);
    vec++; if (dut_time !== 16'h0000) begin miss++; $display("FAIL preset_run_out: got %h want 0000", dut_time); end
    tick(0, 2'd0, 0, 0);
    et = PRESET ? 16'h0003 : 16'h0000;
    vec++; if (dut_time !== et) begin miss++; $display("FAIL preset_stop: got %h want %h", dut_time, et); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(2'd3, 1);
    repeat (TDIV) tick(1, 2'd0, 0, 0);
    vec++; if ({dut_time, o_tick} !== {16'h0959, 1'b1}) begin
      miss++; $display("FAIL pre_async: got %h t=%b want 0959 t=1", dut_time, o_tick);
    end
    #2 reset = 0;
    #1;
    vec++; if ({dut_time, o_zero, o_tick} !== {16'h0000, 1'b1, 1'b0}) begin
      miss++; $display("FAIL async_reset: got %h z=%b t=%b want 0000 z=1 t=0", dut_time, o_zero, o_tick);
    end
    do_reset();
  endtask

  task automatic test_random();
    int len;
    bit r;
    len = 0; r = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (len == 0) begin
        r = $urandom_range(0, 2) == 0;
        len = r ? $urandom_range(1, 40) : $urandom_range(1, 10);
      end
      len--;
      tick(r, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      vec++; if ({dut_time, o_tick, o_zero} !== {m_time(), m_tick, m_zero()}) begin
        miss++;
        $display("FAIL random cycle %0d: got %h t=%b z=%b want %h t=%b z=%b", n, dut_time, o_tick, o_zero, m_time(), m_tick, m_zero());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_edit_wrap();
    test_down_hold();
    test_countdown();
    test_zero_hold();
    test_pause();
    test_preset();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/countdown_sequencer.md
COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, giving clk cycles per one-second count step; legal range is 2 to 2^27.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_run, input, 1, level; high means count down, low means edit or hold.
REQ-005 SHALL have port i_choose, input, 2, selecting the edit digit: 0=segs0, 1=segs1, 2=mins0, 3=mins1.
REQ-006 SHALL have port i_B_U, input, 1, debounced up button, level.
REQ-007 SHALL have port i_B_D, input, 1, debounced down button, level.
REQ-008 SHALL have ports o_segs0, o_segs1, o_mins0, o_mins1, output, 4 each, holding the BCD digits of the time mm:ss.
REQ-009 SHALL have port o_tick, output, 1, registered pulse high for one cycle following each decrement.
REQ-010 SHALL have port o_zero, output, 1, combinational; high when all four digits are 0.

Function
REQ-011 SHALL keep the digits within these ranges: segs0 0-9, segs1 0-5, mins0 0-9, mins1 0-9; the maximum time is 99:59.
REQ-012 SHALL detect a press as a sampled 1 on a button input whose registered previous sample is 0; one press SHALL equal one action, and a held button SHALL NOT auto-repeat.
REQ-013 SHALL apply an up press, when i_run=0, to the digit chosen by i_choose on the same edge that detects the press.
  - The digit increments by 1 and wraps from its maximum to 0.
  - There is no carry into a neighbouring digit.
REQ-014 SHALL apply a down press, when i_run=0, to the chosen digit; the digit decrements by 1 and wraps from 0 to its maximum, with no borrow.
REQ-015 SHALL change no digit when up and down presses are detected on the same edge.
REQ-016 SHALL ignore presses entirely while i_run=1, while still updating the previous-sample registers.
REQ-017 SHALL hold the 27-bit prescaler at 0 while i_run=0.
REQ-018 SHALL handle the prescaler as follows while i_run=1 and o_zero=0:
  - The prescaler increments on each edge.
  - On the edge where it equals TICK_DIV-1, it returns to 0 and the time decrements by one second.
  - o_tick is high for the next cycle.
REQ-019 SHALL therefore perform the first decrement on the TICK_DIV-th consecutive edge at which i_run is sampled 1.
REQ-020 SHALL decrement using a BCD borrow chain:
  - segs0 0 borrows from segs1, giving segs0=9.
  - segs1 0 borrows from mins0, giving segs1=5.
  - mins0 0 borrows from mins1, giving mins0=9.
REQ-021 SHALL, when i_run=1 and o_zero=1, hold the digits and the prescaler and never wrap below 00:00.
REQ-022 SHALL, when i_run falls mid-second, clear the prescaler and hold the digits; the next run SHALL start a full second.
REQ-023 SHALL drive o_tick low in every cycle not covered by REQ-018.

Reset
REQ-024 SHALL, on reset=0 and regardless of clk, force the following until reset returns high:
  - all digits to 0;
  - the prescaler to 0;
  - both previous-sample registers to 0;
  - o_tick to 0.
REQ-025 SHALL drive o_zero=1 during and immediately after reset.
REQ-026 SHALL abort a count or edit in progress when reset asserts, with no partial update.

Configuration
REQ-027 SHALL provide the macro PRESET_RESTORE_EN.
REQ-028 SHALL, when PRESET_RESTORE_EN is defined, behave as follows:
  - A 16-bit preset register captures the four digits on each i_run rising edge.
  - On an i_run falling edge with o_zero=1, the digits reload from the preset on the same edge.
  - The preset resets to 0.
REQ-029 SHALL, when PRESET_RESTORE_EN is undefined, have no preset register, and the digits SHALL remain 00:00 after the count ends.

Verification
REQ-030 SHALL cover, with i_run=0 and i_choose=1: five single-cycle i_B_U pulses from reset -> o_segs1 goes 1,2,3,4,5; a sixth pulse -> o_segs1=0.
REQ-031 SHALL cover, with i_choose=3 and o_mins1=0: an i_B_D pulse -> o_mins1=9 and other digits unchanged; holding i_B_U for 10 cycles -> exactly one increment.
REQ-032 SHALL cover, with TICK_DIV=4 and time 10:00: set i_run=1 -> after 4 edges the time is 09:59 and o_tick is high for 1 cycle; after 4 more edges the time is 09:58.
REQ-033 SHALL cover, with TICK_DIV=4 and time 00:01: run -> 00:00 and o_zero=1; 20 more cycles -> still 00:00 with no o_tick.
REQ-034 SHALL cover, with TICK_DIV=4: i_run high 2 cycles then low 1 cycle then high -> the next decrement occurs exactly 4 edges after run resumes; i_B_U during run -> no change.
REQ-035 SHALL cover, with PRESET_RESTORE_EN defined: set 00:03, run to 00:00, drop i_run -> digits read 00:03 on that edge.
REQ-036 SHALL cover reset asserted mid-count -> all outputs return to their reset values asynchronously.
